// File: rtl/conv_pkg.sv
// conv_pkg: shared definitions for the 3x3 convolution output path.
//   frame_state_e   - frame writer FSM states
//   CROP_C          - warm-up margin (rows/columns) of the 3x3 window
//   out_frame_size  - number of interior pixels written per frame
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } frame_state_e;

    localparam int unsigned CROP_C = 2;

    function automatic int unsigned out_frame_size(input int unsigned depth,
                                                   input int unsigned height);
        return (depth - CROP_C) * (height - CROP_C);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// raster_counter: column/row position of a raster-order pixel stream.
//   clk_i   - clock
//   rst_i   - synchronous active-high reset
//   clear_i - return to pixel (0,0)
//   step_i  - advance one pixel
//   col_o   - current column
//   row_o   - current row
//   last_o  - current position is the final pixel of the frame
module raster_counter #(
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clear_i,
    input  logic                        step_i,
    output logic [$clog2(DEPTH_P)-1:0]  col_o,
    output logic [$clog2(HEIGHT_P)-1:0] row_o,
    output logic                        last_o
);

    localparam int COL_W = $clog2(DEPTH_P);
    localparam int ROW_W = $clog2(HEIGHT_P);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(DEPTH_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_P - 1);

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    assign last_o = (col_q == COL_LAST) && (row_q == ROW_LAST);

    // Stepping past the last pixel wraps to (0,0) so neither counter
    // ever exceeds its terminal value.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (step_i) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/conv_frame_writer.sv
// conv_frame_writer: captures one raster frame per start_i and writes the
// interior pixels (row >= CROP_C and col >= CROP_C) to a frame-buffer port.
//   clk_i       - clock
//   rst_i       - synchronous active-high reset
//   start_i     - arm capture of one frame (sampled in IDLE only)
//   valid_i     - input pixel valid
//   ready_o     - input pixel accepted when valid_i & ready_o
//   data_i      - input pixel
//   we_o        - write request
//   waddr_o     - write address (raster order over the cropped frame)
//   wdata_o     - write data
//   mem_ready_i - memory takes the write when we_o & mem_ready_i
//   busy_o      - frame capture in progress
//   done_o      - one-cycle pulse when the frame's last write is taken
module conv_frame_writer
    import conv_pkg::*;
#(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16,
    parameter int ADDR_W_P = $clog2(out_frame_size(DEPTH_P, HEIGHT_P))
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [WIDTH_P-1:0]  data_i,
    output logic                we_o,
    output logic [ADDR_W_P-1:0] waddr_o,
    output logic [WIDTH_P-1:0]  wdata_o,
    input  logic                mem_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam int COL_W = $clog2(DEPTH_P);
    localparam int ROW_W = $clog2(HEIGHT_P);
    localparam logic [COL_W-1:0] CROP_COL = COL_W'(CROP_C);
    localparam logic [ROW_W-1:0] CROP_ROW = ROW_W'(CROP_C);

    frame_state_e state_q, state_d;

    logic                we_q;
    logic [ADDR_W_P-1:0] waddr_q;
    logic [WIDTH_P-1:0]  wdata_q;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_px;
    logic             accept;
    logic             take;
    logic             crop_in;
    logic             frame_clear;

    assign take        = we_q & mem_ready_i;
    assign ready_o     = (state_q == RUN) && (!we_q || mem_ready_i);
    assign accept      = valid_i & ready_o;
    assign crop_in     = (row >= CROP_ROW) && (col >= CROP_COL);
    assign frame_clear = (state_q == IDLE) && start_i;
    assign busy_o      = (state_q == RUN);

    raster_counter #(
        .DEPTH_P (DEPTH_P),
        .HEIGHT_P(HEIGHT_P)
    ) u_pos (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(frame_clear),
        .step_i (accept),
        .col_o  (col),
        .row_o  (row),
        .last_o (last_px)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE is held while the final write is stalled; done_o fires in the
    // cycle that write is taken.
    always_comb begin
        state_d = state_q;
        done_o  = 1'b0;
        case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (accept && last_px) state_d = DONE;
            DONE: begin
                if (!we_q || mem_ready_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address advances only on a taken write, so raster order over the
    // cropped frame falls out without any multiply.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            if (frame_clear) begin
                waddr_q <= '0;
            end else if (take) begin
                waddr_q <= waddr_q + ADDR_W_P'(1);
            end

            if (accept && crop_in) begin
                we_q    <= 1'b1;
                wdata_q <= data_i;
            end else if (take) begin
                we_q    <= 1'b0;
            end
        end
    end

    assign we_o    = we_q;
    assign waddr_o = waddr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_conv_frame_writer.sv
// tb_conv_frame_writer: directed bench for conv_frame_writer at 4x4.
module tb_conv_frame_writer;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_i = '0;
    logic       we_o;
    logic [1:0] waddr_o;
    logic [7:0] wdata_o;
    logic       mem_ready_i = 1'b1;
    logic       busy_o;
    logic       done_o;

    always #5 clk = ~clk;

    conv_frame_writer #(
        .WIDTH_P (8),
        .DEPTH_P (4),
        .HEIGHT_P(4),
        .ADDR_W_P(2)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_i     (data_i),
        .we_o       (we_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o),
        .mem_ready_i(mem_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    int tests = 0;
    int fails = 0;

    // Observed writes ({addr,data}) and done pulses, sampled mid-cycle.
    logic [9:0] writes_q[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (we_o && mem_ready_i) writes_q.push_back({waddr_o, wdata_o});
        if (done_o) done_cnt++;
    end

    // Per-cycle vectors: inputs, then expected {ready,we,waddr,wdata,busy,done}.
    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        mr;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic v, input logic [7:0] d,
                                input logic mr, input logic r, input logic we,
                                input logic [1:0] a, input logic [7:0] wd,
                                input logic b, input logic dn);
        vec_t t;
        t.st  = st;
        t.v   = v;
        t.d   = d;
        t.mr  = mr;
        t.exp = {r, we, a, wd, b, dn};
        vecs.push_back(t);
    endfunction

    function automatic logic [13:0] outs();
        return {ready_o, we_o, waddr_o, wdata_o, busy_o, done_o};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [9:0] exp_wr[4];

    task automatic check_frame(input string name, input int wr_base, input int done_base);
        check({name, "_nwrites"}, 16'(writes_q.size() - wr_base), 16'd4);
        for (int i = 0; i < 4; i++) begin
            if (wr_base + i < writes_q.size())
                check({name, "_write"}, {6'd0, writes_q[wr_base + i]}, {6'd0, exp_wr[i]});
        end
        check({name, "_done_pulses"}, 16'(done_cnt - done_base), 16'd1);
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 of the cycle after done_o.
    task automatic run_frame(input bit gaps, input bit stall, input bit poke_start);
        int p = 0;
        int cyc = 0;
        int stall_left = 3;
        bit tog = 1'b0;
        bit seen_done = 1'b0;
        start_i = 1'b1;
        valid_i = 1'b0;
        mem_ready_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (p < 16 && cyc < 200) begin
            valid_i = gaps ? tog : 1'b1;
            tog = !tog;
            data_i = 8'(p);
            start_i = poke_start && (p == 5);
            mem_ready_i = 1'b1;
            if (stall && stall_left > 0 && we_o && waddr_o == 2'd1) begin
                mem_ready_i = 1'b0;
                stall_left--;
            end
            @(negedge clk);
            if (!mem_ready_i)
                check("stall_hold", {4'd0, ready_o, we_o, waddr_o, wdata_o},
                      {4'd0, 1'b0, 1'b1, 2'd1, 8'd11});
            if (valid_i && ready_o) p++;
            @(posedge clk); #1;
            cyc++;
        end
        check("frame_pixels_accepted", 16'(p), 16'd16);
        if (stall) check("stall_cycles_applied", 16'(stall_left), 16'd0);
        valid_i = 1'b0;
        start_i = 1'b0;
        mem_ready_i = 1'b1;
        cyc = 0;
        while (!seen_done && cyc < 20) begin
            @(negedge clk);
            seen_done = done_o;
            @(posedge clk); #1;
            cyc++;
        end
        check("done_seen", {15'd0, seen_done}, 16'd1);
    endtask

    int wb, db;

    initial begin
        exp_wr[0] = {2'd0, 8'd10};
        exp_wr[1] = {2'd1, 8'd11};
        exp_wr[2] = {2'd2, 8'd14};
        exp_wr[3] = {2'd3, 8'd15};

        // Back-to-back frame, pixels 0..15, then valid_i in IDLE without start.
        add(1, 0, 8'd0, 1, 0, 0, 2'd0, 8'd0, 0, 0);
        for (int p = 0; p <= 10; p++) add(0, 1, 8'(p), 1, 1, 0, 2'd0, 8'd0, 1, 0);
        add(0, 1, 8'd11, 1, 1, 1, 2'd0, 8'd10, 1, 0);
        add(0, 1, 8'd12, 1, 1, 1, 2'd1, 8'd11, 1, 0);
        add(0, 1, 8'd13, 1, 1, 0, 2'd2, 8'd11, 1, 0);
        add(0, 1, 8'd14, 1, 1, 0, 2'd2, 8'd11, 1, 0);
        add(0, 1, 8'd15, 1, 1, 1, 2'd2, 8'd14, 1, 0);
        add(0, 0, 8'd0,  1, 0, 1, 2'd3, 8'd15, 0, 1);
        add(0, 1, 8'd0,  1, 0, 0, 2'd0, 8'd15, 0, 0);
        add(0, 1, 8'd0,  1, 0, 0, 2'd0, 8'd15, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("reset_state", {2'd0, outs()}, 16'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            start_i     = vecs[i].st;
            valid_i     = vecs[i].v;
            data_i      = vecs[i].d;
            mem_ready_i = vecs[i].mr;
            @(negedge clk);
            check($sformatf("vec%0d", i), {2'd0, outs()}, {2'd0, vecs[i].exp});
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        start_i = 1'b0;

        // Gapped input with a start_i pulse mid-frame.
        wb = writes_q.size(); db = done_cnt;
        run_frame(1'b1, 1'b0, 1'b1);
        check_frame("gaps", wb, db);
        @(posedge clk); #1;

        // Memory stall on the write of pixel 11.
        wb = writes_q.size(); db = done_cnt;
        run_frame(1'b0, 1'b1, 1'b0);
        check_frame("stall", wb, db);
        @(posedge clk); #1;

        // Back-to-back frames: second start in the cycle after done_o.
        wb = writes_q.size(); db = done_cnt;
        run_frame(1'b0, 1'b0, 1'b0);
        check_frame("b2b_first", wb, db);
        wb = writes_q.size(); db = done_cnt;
        run_frame(1'b0, 1'b0, 1'b0);
        check_frame("b2b_second", wb, db);
        @(posedge clk); #1;

        // Reset after pixel 12 is accepted.
        wb = writes_q.size(); db = done_cnt;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int p = 0; p < 13; p++) begin
            valid_i = 1'b1;
            data_i  = 8'(p);
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        rst_i   = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_mid_frame", {2'd0, outs()}, 16'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_no_done", 16'(done_cnt - db), 16'd0);
        check("rst_partial_writes", 16'(writes_q.size() - wb), 16'd2);
        @(posedge clk); #1;

        wb = writes_q.size(); db = done_cnt;
        run_frame(1'b0, 1'b0, 1'b0);
        check_frame("after_reset", wb, db);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
